// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : HighLevelControl
// Purpose  : Shared predictor state encoding and the R/C pipeline record.
// Revision : 1.0
// ============================================================================
package HighLevelControl;

    // Record address fields are sized for the widest supported BIT_COUNT.
    localparam int c_REC_ADDR_BITS = 64;

    typedef enum logic [1:0] {
        StrongNotTaken = 2'd0,
        WeakNotTaken   = 2'd1,
        WeakTaken      = 2'd2,
        StrongTaken    = 2'd3
    } predState;

    typedef struct packed {
        logic                       predict;
        logic [c_REC_ADDR_BITS-1:0] target;
        logic [c_REC_ADDR_BITS-1:0] pc;
    } predRecord;

endpackage
`default_nettype wire

// File: rtl/branch_predictor_counter.sv
`default_nettype none
// ============================================================================
// Module   : predState_counter
// Purpose  : Two-bit saturating direction counter next-state function.
// Revision : 1.0
// ============================================================================
module predState_counter
    import HighLevelControl::*;
(
    input  predState i_state,
    input  logic     i_taken,
    output predState o_next
);

    always_comb begin
        o_next = i_state;
        case (i_state)
            StrongNotTaken: o_next = i_taken ? WeakNotTaken : StrongNotTaken;
            WeakNotTaken:   o_next = i_taken ? WeakTaken    : StrongNotTaken;
            WeakTaken:      o_next = i_taken ? StrongTaken  : WeakNotTaken;
            StrongTaken:    o_next = i_taken ? StrongTaken  : WeakTaken;
            default:        o_next = WeakNotTaken;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters, I->R->C record pipeline
//            and C-stage resolve/compare with table update.
// Revision : 1.0
// ============================================================================
module branch_predictor
    import HighLevelControl::*;
#(
    parameter int BIT_COUNT   = 32,
    parameter int ENTRY_COUNT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_COUNT-1:0] PC_I,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 ResolveValid_C,
    input  logic                 ResolveTaken_C,
    input  logic [BIT_COUNT-1:0] ResolveTarget_C,
    output logic                 Predict,
    output logic [BIT_COUNT-1:0] Prediction,
    output logic                 PredictionCorrect_C,
    output logic                 Mispredict_C
);

    localparam int c_IDX   = $clog2(ENTRY_COUNT);
    localparam int c_TAG_W = BIT_COUNT - c_IDX - 2;

    logic                 r_valid  [ENTRY_COUNT];
    logic [c_TAG_W-1:0]   r_tag    [ENTRY_COUNT];
    logic [BIT_COUNT-1:1] r_target [ENTRY_COUNT];
    predState             r_state  [ENTRY_COUNT];

    predRecord r_rec_r;
    predRecord r_rec_c;
    predRecord w_rec_i;

    logic [c_IDX-1:0]     w_idx_i;
    logic [c_TAG_W-1:0]   w_tag_i;
    logic                 w_hit_i;
    logic                 w_predict_i;
    logic [BIT_COUNT-1:0] w_prediction_i;

    logic [c_IDX-1:0]     w_idx_c;
    logic [c_TAG_W-1:0]   w_tag_c;
    logic                 w_hit_c;
    logic                 w_pred_c;
    logic [BIT_COUNT-1:1] w_target_c;
    logic                 w_correct_c;
    logic                 w_mispredict_c;
    logic                 w_upd_en;
    logic                 w_clr_en;
    predState             w_state_next;
    logic                 w_unused_bits;

    // ------------------------------------------------------------------
    // I-stage lookup (purely combinational)
    // ------------------------------------------------------------------
    assign w_idx_i     = PC_I[c_IDX+1:2];
    assign w_tag_i     = PC_I[BIT_COUNT-1:c_IDX+2];
    assign w_hit_i     = r_valid[w_idx_i] && (r_tag[w_idx_i] == w_tag_i);
    assign w_predict_i = w_hit_i &&
                         ((r_state[w_idx_i] == WeakTaken) ||
                          (r_state[w_idx_i] == StrongTaken));
    assign w_prediction_i = w_hit_i ? {r_target[w_idx_i], 1'b0} : '0;

    always_comb begin
        w_rec_i                      = '0;
        w_rec_i.predict              = w_predict_i;
        w_rec_i.target[BIT_COUNT-1:0] = w_prediction_i;
        w_rec_i.pc[BIT_COUNT-1:0]    = PC_I;
    end

    // ------------------------------------------------------------------
    // R/C record pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rec_r <= '0;
            r_rec_c <= '0;
        end else if (!Stall) begin
            if (Flush) begin
                r_rec_r <= '0;
                r_rec_c <= '0;
            end else begin
                r_rec_r <= w_rec_i;
                r_rec_c <= r_rec_r;
            end
        end
    end

    // ------------------------------------------------------------------
    // C-stage compare
    // ------------------------------------------------------------------
    assign w_pred_c   = r_rec_c.predict;
    assign w_target_c = r_rec_c.target[BIT_COUNT-1:1];
    assign w_idx_c    = r_rec_c.pc[c_IDX+1:2];
    assign w_tag_c    = r_rec_c.pc[BIT_COUNT-1:c_IDX+2];
    assign w_hit_c    = r_valid[w_idx_c] && (r_tag[w_idx_c] == w_tag_c);

    assign w_correct_c = ResolveValid_C &&
                         (ResolveTaken_C == w_pred_c) &&
                         (!ResolveTaken_C ||
                          (ResolveTarget_C[BIT_COUNT-1:1] == w_target_c));
    assign w_mispredict_c = (ResolveValid_C && !w_correct_c) ||
                            (!ResolveValid_C && w_pred_c);

    // Gate with reset so nothing derived from live resolve inputs escapes.
    assign Predict             = reset & w_predict_i;
    assign Prediction          = reset ? w_prediction_i : '0;
    assign PredictionCorrect_C = reset & w_correct_c;
    assign Mispredict_C        = reset & w_mispredict_c;

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    assign w_upd_en = !Stall && ResolveValid_C;
    assign w_clr_en = !Stall && !ResolveValid_C && w_pred_c && w_hit_c;

    predState_counter u_counter (
        .i_state (r_state[w_idx_c]),
        .i_taken (ResolveTaken_C),
        .o_next  (w_state_next)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < ENTRY_COUNT; e++) begin
                r_valid[e]  <= 1'b0;
                r_tag[e]    <= '0;
                r_target[e] <= '0;
                r_state[e]  <= WeakNotTaken;
            end
        end else if (w_upd_en) begin
            if (w_hit_c) begin
                r_state[w_idx_c] <= w_state_next;
                if (ResolveTaken_C) begin
                    r_target[w_idx_c] <= ResolveTarget_C[BIT_COUNT-1:1];
                end
            end else if (ResolveTaken_C) begin
                r_valid[w_idx_c]  <= 1'b1;
                r_tag[w_idx_c]    <= w_tag_c;
                r_target[w_idx_c] <= ResolveTarget_C[BIT_COUNT-1:1];
                r_state[w_idx_c]  <= WeakTaken;
            end
        end else if (w_clr_en) begin
            // Predicted-taken instruction turned out not to be a branch.
            r_valid[w_idx_c] <= 1'b0;
        end
    end

    assign w_unused_bits = ^{PC_I[1:0], ResolveTarget_C[0],
                             r_rec_c.target, r_rec_c.pc};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed + randomized self-checking bench with reference model.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

    localparam int c_N   = 16;
    localparam int c_IDX = 4;

    logic        clk;
    logic        reset;
    logic [31:0] PC_I;
    logic        Stall;
    logic        Flush;
    logic        ResolveValid_C;
    logic        ResolveTaken_C;
    logic [31:0] ResolveTarget_C;
    logic        Predict;
    logic [31:0] Prediction;
    logic        PredictionCorrect_C;
    logic        Mispredict_C;

    branch_predictor #(.BIT_COUNT(32), .ENTRY_COUNT(c_N)) dut (
        .clk                 (clk),
        .reset               (reset),
        .PC_I                (PC_I),
        .Stall               (Stall),
        .Flush               (Flush),
        .ResolveValid_C      (ResolveValid_C),
        .ResolveTaken_C      (ResolveTaken_C),
        .ResolveTarget_C     (ResolveTarget_C),
        .Predict             (Predict),
        .Prediction          (Prediction),
        .PredictionCorrect_C (PredictionCorrect_C),
        .Mispredict_C        (Mispredict_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-entry counter as an integer 0..3, full addresses.
    bit          m_valid [c_N];
    int unsigned m_cnt   [c_N];
    logic [31:0] m_tag   [c_N];
    logic [31:0] m_tgt   [c_N];
    bit          m_r_pred, m_c_pred;
    logic [31:0] m_r_tgt, m_c_tgt, m_r_pc, m_c_pc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < c_N; e++) begin
            m_valid[e] = 1'b0;
            m_cnt[e]   = 1;
            m_tag[e]   = '0;
            m_tgt[e]   = '0;
        end
        m_r_pred = 0; m_c_pred = 0;
        m_r_tgt = '0; m_c_tgt = '0; m_r_pc = '0; m_c_pc = '0;
    endtask

    // Drive one cycle, check outputs against the model, then advance the model.
    task automatic run_cycle(input logic [31:0] pc, input logic stall, input logic flush,
                             input logic rv, input logic rt, input logic [31:0] rtgt);
        int unsigned ii, ci;
        bit hit_i, hit_c, e_pred, e_corr, e_misp;
        logic [31:0] e_tgt;
        @(negedge clk);
        PC_I = pc; Stall = stall; Flush = flush;
        ResolveValid_C = rv; ResolveTaken_C = rt; ResolveTarget_C = rtgt;
        #2;
        ii     = (pc >> 2) % c_N;
        hit_i  = m_valid[ii] && (m_tag[ii] == (pc >> (c_IDX + 2)));
        e_pred = hit_i && (m_cnt[ii] >= 2);
        e_tgt  = hit_i ? (m_tgt[ii] & 32'hFFFF_FFFE) : 32'h0;
        e_corr = rv && (rt == m_c_pred) && (!rt || ((rtgt >> 1) == (m_c_tgt >> 1)));
        e_misp = (rv && !e_corr) || (!rv && m_c_pred);
        check_eq("predict",    {31'b0, Predict}, {31'b0, e_pred});
        check_eq("prediction", Prediction, e_tgt);
        check_eq("correct_c",  {31'b0, PredictionCorrect_C}, {31'b0, e_corr});
        check_eq("mispred_c",  {31'b0, Mispredict_C}, {31'b0, e_misp});
        if (!stall) begin
            ci    = (m_c_pc >> 2) % c_N;
            hit_c = m_valid[ci] && (m_tag[ci] == (m_c_pc >> (c_IDX + 2)));
            if (rv) begin
                if (hit_c) begin
                    if (rt) begin
                        m_cnt[ci] = (m_cnt[ci] == 3) ? 3 : m_cnt[ci] + 1;
                        m_tgt[ci] = rtgt;
                    end else begin
                        m_cnt[ci] = (m_cnt[ci] == 0) ? 0 : m_cnt[ci] - 1;
                    end
                end else if (rt) begin
                    m_valid[ci] = 1'b1;
                    m_tag[ci]   = m_c_pc >> (c_IDX + 2);
                    m_tgt[ci]   = rtgt;
                    m_cnt[ci]   = 2;
                end
            end else if (m_c_pred && hit_c) begin
                m_valid[ci] = 1'b0;
            end
            if (flush) begin
                m_r_pred = 0; m_r_tgt = '0; m_r_pc = '0;
                m_c_pred = 0; m_c_tgt = '0; m_c_pc = '0;
            end else begin
                m_c_pred = m_r_pred; m_c_tgt = m_r_tgt; m_c_pc = m_r_pc;
                m_r_pred = e_pred;   m_r_tgt = e_tgt;   m_r_pc = pc;
            end
        end
    endtask

    task automatic run(input logic [31:0] pc);
        run_cycle(pc, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, tg;
        logic        rt;
        model_reset();
        reset = 1'b0; Stall = 1'b1; Flush = 1'b0;
        PC_I = 32'h100; ResolveValid_C = 1'b1; ResolveTaken_C = 1'b0; ResolveTarget_C = 32'h0;
        #2;
        check_eq("rst_predict",    {31'b0, Predict}, 32'h0);
        check_eq("rst_prediction", Prediction, 32'h0);
        check_eq("rst_correct",    {31'b0, PredictionCorrect_C}, 32'h0);
        check_eq("rst_mispred",    {31'b0, Mispredict_C}, 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Cold lookup, then allocate 0x100 -> 0x200
        run(32'h100);
        check_eq("cold_predict", {31'b0, Predict}, 32'h0);
        check_eq("cold_target",  Prediction, 32'h0);
        run(32'h104);
        run_cycle(32'h108, 0, 0, 1, 1, 32'h200);
        run(32'h100);
        check_eq("alloc_predict", {31'b0, Predict}, 32'h1);
        check_eq("alloc_target",  Prediction, 32'h200);

        // Wrong target at C: mispredict, target rewritten
        run(32'h10C);
        run_cycle(32'h110, 0, 0, 1, 1, 32'h300);
        check_eq("tgt_mispred", {31'b0, Mispredict_C}, 32'h1);
        check_eq("tgt_correct", {31'b0, PredictionCorrect_C}, 32'h0);
        run(32'h100);
        check_eq("tgt_new", Prediction, 32'h300);

        // Predicted non-branch reaches C, then train/untrain entry 8
        run(32'h120);
        run(32'h10C);
        check_eq("nonbr_mispred", {31'b0, Mispredict_C}, 32'h1);
        run_cycle(32'h110, 0, 0, 1, 1, 32'h400);
        run(32'h120);
        run(32'h120);
        run_cycle(32'h120, 0, 0, 1, 0, 32'h0);
        run_cycle(32'h10C, 0, 0, 1, 0, 32'h0);
        run(32'h120);
        check_eq("untrain_predict", {31'b0, Predict}, 32'h0);

        // Stall holds everything; flush clears C one edge later
        run(32'h200);
        run(32'h204);
        for (int k = 0; k < 3; k++) run_cycle(32'h208, 1, 0, 1, 1, 32'h500);
        run_cycle(32'h20C, 0, 1, 0, 0, 32'h0);
        run(32'h210);
        check_eq("flush_mispred", {31'b0, Mispredict_C}, 32'h0);

        // Same-cycle lookup/update of index 4
        run(32'h010);
        run(32'h014);
        run_cycle(32'h010, 0, 0, 1, 1, 32'h600);
        check_eq("bypass_old", {31'b0, Predict}, 32'h0);
        run(32'h010);
        check_eq("bypass_new_p", {31'b0, Predict}, 32'h1);
        check_eq("bypass_new_t", Prediction, 32'h600);

        // Randomized traffic over a small aliasing address pool
        for (int k = 0; k < 3000; k++) begin
            pc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
            rt = ($urandom_range(0, 2) == 0) ? ~m_c_pred : m_c_pred;
            tg = ($urandom_range(0, 1) == 1) ? (m_c_tgt | $urandom_range(0, 1)) : $urandom;
            run_cycle(pc, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0),
                      ($urandom_range(0, 1) == 1), rt, tg);
        end

        // Reset asserted with an update pending aborts the write
        @(negedge clk);
        PC_I = 32'h010; Stall = 1'b0; Flush = 1'b0;
        ResolveValid_C = 1'b1; ResolveTaken_C = 1'b1; ResolveTarget_C = 32'h700;
        #1 reset = 1'b0;
        #1;
        check_eq("midrst_predict", {31'b0, Predict}, 32'h0);
        check_eq("midrst_target",  Prediction, 32'h0);
        check_eq("midrst_correct", {31'b0, PredictionCorrect_C}, 32'h0);
        check_eq("midrst_mispred", {31'b0, Mispredict_C}, 32'h0);
        model_reset();
        @(negedge clk);
        Stall = 1'b1;
        #1 reset = 1'b1;
        run(32'h010);
        check_eq("postrst_predict", {31'b0, Predict}, 32'h0);
        for (int k = 0; k < 4; k++) run(32'h100 + 32'(k * 4));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
